// File: rtl/core_ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its
// data-side sibling.
package core_ifetch_pkg;

  localparam int IF_ADDR_W = 64;
  localparam int IF_DATA_W = 64;
  localparam int IF_TAG_W  = IF_ADDR_W - 3;

  typedef enum logic {
    IFETCH_IDLE,
    IFETCH_WAIT
  } ifetch_state_t;

  // Returned on cycles that carry no valid instruction.
  localparam logic [31:0] NOP_INST = 32'h0;

  typedef struct packed {
    logic                 req;
    logic [IF_ADDR_W-1:0] addr;
  } imem_req_t;

  typedef struct packed {
    logic                 rvalid;
    logic [IF_DATA_W-1:0] rdata;
  } imem_rsp_t;

  // Pick the 32-bit instruction out of a doubleword using pc[2].
  function automatic logic [31:0] word_sel(input logic [IF_DATA_W-1:0] dw,
                                           input logic hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/core_ifetch_buf.sv
// One-entry doubleword fetch buffer: tag lookup, word select, fill and
// invalidate. An invalidate in the same cycle suppresses the hit.
module core_ifetch_buf
  import core_ifetch_pkg::*;
#(
  parameter int TAG_W  = IF_TAG_W,
  parameter int DATA_W = IF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic              word_hi,
  input  logic              inval,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  output logic              hit,
  output logic [31:0]       word
);

  logic              buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]  buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  assign hit  = buf_valid_q && (buf_tag_q == lookup_tag) && !inval;
  assign word = word_hi ? buf_data_q[DATA_W-1:DATA_W/2] : buf_data_q[DATA_W/2-1:0];

  // Next buffer contents: invalidate wins, otherwise a fill loads tag+data.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (inval) begin
      buf_valid_d = 1'b0;
    end else if (fill_en) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = fill_tag;
      buf_data_d  = fill_data;
    end
  end

  // Buffer registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      // NOTE: the data register is cleared too so inst never shows X after reset.
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

endmodule

// File: rtl/core_ifetch.sv
// Instruction fetch unit: turns the IF pc into a 32-bit instruction, owning
// the imem request/response handshake and a one-doubleword buffer.
module core_ifetch
  import core_ifetch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              inval,
  output logic [31:0]       inst,
  output logic              fetch_stall,
  output logic              inst_misaligned,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [31:0]       miss_count
);

  localparam int TAG_W = ADDR_W - 3;

  ifetch_state_t    state_q, state_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic             stale_q, stale_d;
  logic [31:0]      miss_count_q, miss_count_d;

  logic [TAG_W-1:0] pc_tag;
  logic             pc_misaligned;
  logic             buf_hit;
  logic [31:0]      buf_word;
  logic             fill_en;

  assign pc_tag        = pc[ADDR_W-1:3];
  assign pc_misaligned = |pc[1:0];
  assign imem_addr     = {pc[ADDR_W-1:3], 3'b000};
  assign miss_count    = miss_count_q;

  core_ifetch_buf #(
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clock      (clock),
    .reset      (reset),
    .lookup_tag (pc_tag),
    .word_hi    (pc[2]),
    .inval      (inval),
    .fill_en    (fill_en),
    .fill_tag   (pc_tag),
    .fill_data  (imem_rdata),
    .hit        (buf_hit),
    .word       (buf_word)
  );

  // Handshake FSM: hit/misaligned service in IDLE, one outstanding request in WAIT.
  always_comb begin
    state_d         = state_q;
    req_tag_d       = req_tag_q;
    stale_d         = stale_q;
    miss_count_d    = miss_count_q;
    inst            = NOP_INST;
    fetch_stall     = 1'b1;
    inst_misaligned = 1'b0;
    imem_req        = 1'b0;
    fill_en         = 1'b0;
    case (state_q)
      IFETCH_IDLE: begin
        if (pc_misaligned) begin
          inst_misaligned = 1'b1;
          fetch_stall     = 1'b0;
        end else if (buf_hit) begin
          inst        = buf_word;
          fetch_stall = 1'b0;
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            req_tag_d    = pc_tag;
            stale_d      = 1'b0;
            miss_count_d = miss_count_q + 32'd1;
            state_d      = IFETCH_WAIT;
          end
        end
      end
      IFETCH_WAIT: begin
        stale_d = stale_q | inval;
        if (imem_rvalid) begin
          state_d = IFETCH_IDLE;
          // Only a live response for the pc still being fetched is kept.
          if (!stale_q && !inval && (req_tag_q == pc_tag)) begin
            fill_en = 1'b1;
            // A misaligned pc keeps stalling; its flag is raised back in IDLE.
            if (!pc_misaligned) begin
              inst        = word_sel(imem_rdata, pc[2]);
              fetch_stall = 1'b0;
            end
          end
        end
      end
      default: state_d = IFETCH_IDLE;
    endcase
  end

  // FSM, request tag, stale flag and miss counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IFETCH_IDLE;
      req_tag_q    <= '0;
      stale_q      <= 1'b0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      req_tag_q    <= req_tag_d;
      stale_q      <= stale_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule
